// File: rtl/player_lane_fsm.sv
// Player ship lane controller: edge-detected left/right moves across NUM_POS lanes, each move
// sequenced as an erase pass of the old sprite followed by a draw pass of the new one.
module player_lane_fsm #(
  parameter int unsigned NUM_POS     = 4,
  parameter int unsigned POS_W       = 2,
  parameter int unsigned DRAW_CYCLES = 100,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WRAP        = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               left_key,
  input  logic               right_key,
  input  logic               redraw_req,
  output logic [POS_W-1:0]   pos,
  output logic [POS_W-1:0]   draw_pos,
  output logic [CNT_W-1:0]   pix_count,
  output logic               in_erase,
  output logic               in_draw,
  output logic               busy,
  output logic [NUM_POS-1:0] ld_pos,
  output logic               move_done
);

  typedef enum logic [1:0] {StIdle, StErase, StDraw} state_e;

  localparam logic [POS_W-1:0] LastPos = POS_W'(NUM_POS - 1);
  localparam logic [CNT_W-1:0] LastPix = CNT_W'(DRAW_CYCLES - 1);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   pix_q, pix_d;
  logic               left_q, right_q;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_right_q, pend_right_d;
  logic               move_flag_q, move_flag_d;

  logic               l_edge, r_edge, pass_last;
  logic               req_valid, req_right, req_legal;
  logic [POS_W-1:0]   req_target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StDraw;
      pos_q        <= '0;
      target_q     <= '0;
      pix_q        <= '0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_right_q <= 1'b0;
      move_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      target_q     <= target_d;
      pix_q        <= pix_d;
      left_q       <= left_key;
      right_q      <= right_key;
      pend_valid_q <= pend_valid_d;
      pend_right_q <= pend_right_d;
      move_flag_q  <= move_flag_d;
    end
  end

  always_comb begin
    l_edge    = left_key & ~left_q;
    r_edge    = right_key & ~right_q;
    pass_last = (pix_q == LastPix);

    // A buffered move outranks any fresh edge seen in the same idle cycle.
    if (state_q == StIdle && pend_valid_q) begin
      req_valid = 1'b1;
      req_right = pend_right_q;
    end else begin
      req_valid = l_edge ^ r_edge;
      req_right = r_edge;
    end

    req_legal  = 1'b1;
    req_target = pos_q;
    if (req_right) begin
      if (pos_q == LastPos) begin
        req_legal  = (WRAP != 0);
        req_target = '0;
      end else begin
        req_target = pos_q + POS_W'(1);
      end
    end else begin
      if (pos_q == '0) begin
        req_legal  = (WRAP != 0);
        req_target = LastPos;
      end else begin
        req_target = pos_q - POS_W'(1);
      end
    end

    state_d      = state_q;
    pos_d        = pos_q;
    target_d     = target_q;
    pix_d        = pix_q;
    pend_valid_d = pend_valid_q;
    pend_right_d = pend_right_q;
    move_flag_d  = move_flag_q;

    // Pending buffer: loaded while busy, or refilled in the idle cycle that consumes it.
    if (state_q != StIdle || pend_valid_q) begin
      if (state_q == StIdle) pend_valid_d = 1'b0;
      if (l_edge && r_edge) begin
        pend_valid_d = 1'b0;
      end else if (l_edge || r_edge) begin
        pend_valid_d = 1'b1;
        pend_right_d = r_edge;
      end
    end

    unique case (state_q)
      StIdle: begin
        pix_d = '0;
        if (req_valid && req_legal) begin
          state_d  = StErase;
          target_d = req_target;
        end else if (!pend_valid_q && redraw_req) begin
          state_d     = StDraw;
          move_flag_d = 1'b0;
        end
      end
      StErase: begin
        if (pass_last) begin
          pix_d       = '0;
          pos_d       = target_q;
          move_flag_d = 1'b1;
          state_d     = StDraw;
        end else begin
          pix_d = pix_q + CNT_W'(1);
        end
      end
      StDraw: begin
        if (pass_last) begin
          pix_d       = '0;
          move_flag_d = 1'b0;
          state_d     = StIdle;
        end else begin
          pix_d = pix_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pos       = pos_q;
  assign draw_pos  = pos_q;
  assign pix_count = pix_q;
  assign in_erase  = (state_q == StErase);
  assign in_draw   = (state_q == StDraw);
  assign busy      = (state_q == StErase) || (state_q == StDraw);
  assign ld_pos    = (state_q == StIdle) ? (NUM_POS'(1) << pos_q) : '0;
  assign move_done = (state_q == StDraw) && pass_last && move_flag_q;

endmodule
